mc_request_queue: RTL

//  Multi-channel slotted request store: N_CHANNELS producers share one pool of 2**LSIZE slots.

---
 rtl/mc_request_queue.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mc_request_queue.sv
// Multi-channel slotted request store: shared slot pool with FIFO free list,
// per-channel quota/occupancy, slot-valid tracking and sticky error flags.
module mc_request_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int LSIZE      = 6,
  parameter int N_CHANNELS = 4,
  parameter int MAX_PER_CH = 2**LSIZE,
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           initialize,
  input  logic                           push_valid_in,
  input  logic [CW-1:0]                  push_chan_in,
  input  logic [DATA_WIDTH-1:0]          push_data_in,
  output logic                           push_ready_out,
  output logic                           push_done_out,
  output logic [LSIZE-1:0]               push_slot_id_out,
  output logic [CW-1:0]                  push_chan_out,
  input  logic                           pop_en_in,
  input  logic [LSIZE-1:0]               pop_slot_id_in,
  output logic                           pop_valid_out,
  output logic [DATA_WIDTH-1:0]          pop_data_out,
  output logic [CW-1:0]                  pop_chan_out,
  output logic [N_CHANNELS*(LSIZE+1)-1:0] occupancy_out,
  output logic [LSIZE:0]                 free_count_out,
  output logic                           initialized,
  output logic                           error_invalid_pop,
  output logic                           error_bad_chan
);

  localparam int SLOTS = 2**LSIZE;
  localparam logic [LSIZE:0] SLOTS_C = (LSIZE+1)'(SLOTS);
  localparam logic [LSIZE:0] MAXP    = (LSIZE+1)'(MAX_PER_CH);
  localparam logic [CW:0]    NCH     = (CW+1)'(N_CHANNELS);
  localparam logic [LSIZE-1:0] LAST  = LSIZE'(SLOTS-1);

  typedef enum logic [1:0] {IDLE, INIT, READY} state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   ram_q   [SLOTS];
  logic [CW-1:0]           owner_q [SLOTS];
  logic [LSIZE-1:0]        fl_q    [SLOTS];
  logic [SLOTS-1:0]        valid_q;
  logic [LSIZE:0]          occ_q   [N_CHANNELS];
  logic [LSIZE-1:0]        head_q, tail_q, init_q;
  logic [LSIZE:0]          free_q;
  logic                    pend_q;
  logic [LSIZE-1:0]        pend_slot_q;
  logic                    push_done_q, pop_valid_q;
  logic [LSIZE-1:0]        push_slot_q;
  logic [CW-1:0]           push_chan_q, pop_chan_q;
  logic [DATA_WIDTH-1:0]   pop_data_q;
  logic                    init_done_q, err_pop_q, err_chan_q;

  logic                    chan_ok, push_fire, pop_ok;
  logic [LSIZE:0]          occ_sel, avail;
  logic [LSIZE-1:0]        alloc;
  logic [CW-1:0]           pop_own;

  // Handshake and allocation decode; a freed slot still pending its
  // free-list write is counted as free but not yet allocatable.
  always_comb begin
    chan_ok   = {1'b0, push_chan_in} < NCH;
    occ_sel   = chan_ok ? occ_q[push_chan_in] : '0;
    avail     = free_q - {{LSIZE{1'b0}}, pend_q};
    alloc     = fl_q[head_q];
    pop_own   = owner_q[pop_slot_id_in];
    push_ready_out = (state_q == READY) && (avail != '0)
                     && (occ_sel < MAXP) && chan_ok;
    push_fire = push_valid_in && push_ready_out;
    pop_ok    = (state_q == READY) && pop_en_in
                && valid_q[pop_slot_id_in];
  end

  // Slot storage, owner table and free list memories.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      fl_q[init_q]    <= init_q;
      ram_q[init_q]   <= '0;
      owner_q[init_q] <= '0;
    end else begin
      if (push_fire) begin
        ram_q[alloc]   <= push_data_in;
        owner_q[alloc] <= push_chan_in;
      end
      if (pend_q) fl_q[tail_q] <= pend_slot_q;
    end
  end

  // Control FSM, counters, valid bits and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      init_q      <= '0;
      free_q      <= '0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
      push_done_q <= 1'b0;
      push_slot_q <= '0;
      push_chan_q <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      pop_chan_q  <= '0;
      init_done_q <= 1'b0;
      err_pop_q   <= 1'b0;
      err_chan_q  <= 1'b0;
      for (int c = 0; c < N_CHANNELS; c++) occ_q[c] <= '0;
    end else begin
      push_done_q <= 1'b0;
      pop_valid_q <= 1'b0;
      if (initialize && state_q != INIT) begin
        state_q     <= INIT;
        valid_q     <= '0;
        head_q      <= '0;
        tail_q      <= '0;
        init_q      <= '0;
        free_q      <= '0;
        pend_q      <= 1'b0;
        init_done_q <= 1'b0;
        err_pop_q   <= 1'b0;
        err_chan_q  <= 1'b0;
        for (int c = 0; c < N_CHANNELS; c++) occ_q[c] <= '0;
      end else begin
        unique case (state_q)
          IDLE: ;
          INIT: begin
            init_q <= init_q + 1'b1;
            if (init_q == LAST) begin
              state_q     <= READY;
              free_q      <= SLOTS_C;
              init_done_q <= 1'b1;
            end
          end
          READY: begin
            if (push_valid_in && !chan_ok) err_chan_q <= 1'b1;
            if (pop_en_in && !valid_q[pop_slot_id_in]) err_pop_q <= 1'b1;
            if (push_fire) begin
              head_q         <= head_q + 1'b1;
              valid_q[alloc] <= 1'b1;
              push_done_q    <= 1'b1;
              push_slot_q    <= alloc;
              push_chan_q    <= push_chan_in;
            end
            if (pend_q) tail_q <= tail_q + 1'b1;
            pend_q      <= pop_ok;
            pend_slot_q <= pop_slot_id_in;
            if (pop_ok) begin
              valid_q[pop_slot_id_in] <= 1'b0;
              pop_valid_q <= 1'b1;
              pop_data_q  <= ram_q[pop_slot_id_in];
              pop_chan_q  <= pop_own;
            end
            free_q <= free_q + (LSIZE+1)'(pop_ok)
                      - (LSIZE+1)'(push_fire);
            for (int c = 0; c < N_CHANNELS; c++) begin
              occ_q[c] <= occ_q[c]
                + (LSIZE+1)'(push_fire && push_chan_in == CW'(c))
                - (LSIZE+1)'(pop_ok && pop_own == CW'(c));
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Flatten per-channel occupancy, channel 0 in the LSBs.
  always_comb begin
    occupancy_out = '0;
    for (int c = 0; c < N_CHANNELS; c++)
      occupancy_out[c*(LSIZE+1) +: (LSIZE+1)] = occ_q[c];
  end

  assign push_done_out     = push_done_q;
  assign push_slot_id_out  = push_slot_q;
  assign push_chan_out     = push_chan_q;
  assign pop_valid_out     = pop_valid_q;
  assign pop_data_out      = pop_data_q;
  assign pop_chan_out      = pop_chan_q;
  assign free_count_out    = free_q;
  assign initialized       = init_done_q;
  assign error_invalid_pop = err_pop_q;
  assign error_bad_chan    = err_chan_q;

endmodule
